// File: rtl/logic_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_unit_pkg
//
// Shared definitions for the registered logic unit:
//   - opcode_t      : 3-bit opcode type
//   - OP_*          : opcode encodings for the eight bitwise operations
//   - LU_MAX_W      : widest operand the helper function handles
//   - f_logic_op()  : combinational evaluation of one opcode on two operands
//
// The helper works on a fixed LU_MAX_W-bit word so a single package function
// serves every WIDTH instantiation. Every operation is purely bitwise, so the
// caller zero-extends its operands and keeps only the low WIDTH bits of the
// result; the upper bits are simply never used and optimise away.
// -----------------------------------------------------------------------------
package logic_unit_pkg;

    // Upper bound on the WIDTH parameter of logic_unit_pipe.
    localparam int LU_MAX_W = 256;

    typedef logic [2:0]          opcode_t;
    typedef logic [LU_MAX_W-1:0] lu_word_t;

    localparam opcode_t OP_AND  = 3'b000;
    localparam opcode_t OP_OR   = 3'b001;
    localparam opcode_t OP_NOT  = 3'b010;   // operand B ignored
    localparam opcode_t OP_XOR  = 3'b011;
    localparam opcode_t OP_NAND = 3'b100;
    localparam opcode_t OP_NOR  = 3'b101;
    localparam opcode_t OP_XNOR = 3'b110;
    localparam opcode_t OP_PASS = 3'b111;   // result = operand A

    function automatic lu_word_t f_logic_op(
        input opcode_t  op,
        input lu_word_t a,
        input lu_word_t b
    );
        lu_word_t r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NOT:  r = ~a;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XNOR: r = ~(a ^ b);
            default: r = a;             // OP_PASS
        endcase
        return r;
    endfunction

endpackage : logic_unit_pkg

// File: rtl/logic_unit_fifo.sv
// -----------------------------------------------------------------------------
// logic_unit_fifo
//
// DEPTH-entry circular queue used as the output buffer of logic_unit_pipe.
// Control is just an occupancy count (0..DEPTH) and two wrapping pointers;
// there is no separate state machine.
//
// Parameters:
//   DEPTH  : number of entries (power of two, >= 2)
//   DATA_W : payload width in bits
//
// Ports:
//   iClk    in   rising-edge clock
//   iRst_n  in   asynchronous active-low reset (count and pointers to 0)
//   iPush   in   write iData at the tail (ignored when full)
//   iData   in   payload to write
//   iPop    in   remove the head entry (ignored when empty)
//   oHead   out  payload at the head (meaningless when empty)
//   oFull   out  count == DEPTH
//   oEmpty  out  count == 0
//
// A push and a pop in the same cycle on a partly filled queue leave the count
// unchanged and advance both pointers. Because push is gated by full and pop
// by empty, a full queue only pops and an empty queue only pushes.
// -----------------------------------------------------------------------------
module logic_unit_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 8
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iPush,
    input  logic [DATA_W-1:0] iData,
    input  logic              iPop,
    output logic [DATA_W-1:0] oHead,
    output logic              oFull,
    output logic              oEmpty
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W:0]    count;
    logic              doPush;
    logic              doPop;
    logic [DATA_W-1:0] mem [DEPTH];

    // Flags come straight from the registered count, so they are glitch-free
    // and never depend on the same-cycle handshake inputs.
    assign oFull  = (count == FULL_COUNT);
    assign oEmpty = (count == '0);

    assign doPush = iPush && !oFull;
    assign doPop  = iPop  && !oEmpty;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap by overflowing.
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately left out of reset; an empty
    // queue never exposes it, and an unreset array maps onto plain RAM/flops
    // without a reset tree.
    always_ff @(posedge iClk) begin
        if (doPush) begin
            mem[wrPtr] <= iData;
        end
    end

    assign oHead = mem[rdPtr];

endmodule : logic_unit_fifo

// File: rtl/logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// logic_unit_pipe
//
// Registered bitwise logic unit. Each accepted operand pair is evaluated under
// a 3-bit opcode (AND, OR, NOT, XOR, NAND, NOR, XNOR, PASS) and the result is
// written into a DEPTH-entry output queue. Both sides use valid/ready
// handshakes; the head entry is presented with zero/all-ones flags and a
// running count of completed (popped) transactions.
//
// Parameters:
//   WIDTH : operand/result width in bits (1 .. LU_MAX_W)
//   DEPTH : output queue entries (power of two, >= 2)
//   CNT_W : width of the transaction counter
//
// Ports:
//   iClk      in   rising-edge clock
//   iRst_n    in   asynchronous active-low reset
//   iValid    in   operand/opcode valid
//   oReady    out  queue not full (from registered count only)
//   iOp       in   opcode (see logic_unit_pkg)
//   iA, iB    in   operands
//   oValid    out  queue head valid
//   iReady    in   downstream accepts head
//   oResult   out  head result, 0 when empty
//   oZero     out  head result == 0, 0 when empty
//   oOnes     out  head result all ones, 0 when empty
//   oTxCount  out  results popped since reset, modulo 2^CNT_W
//   oParity   out  XOR-reduction of head result, 0 when empty
//                  (present only with LOGIC_UNIT_PARITY_EN defined)
//
// Build option:
//   LOGIC_UNIT_PARITY_EN : adds oParity and stores one parity bit per entry.
//
// Latency is one cycle from acceptance to the head when the queue is empty.
// oReady does not look at iReady, so a full queue never passes a new operand
// through in the same cycle as a pop.
// -----------------------------------------------------------------------------
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [2:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oResult,
    output logic             oZero,
    output logic             oOnes,
    output logic [CNT_W-1:0] oTxCount
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             oParity
`endif
);

`ifdef LOGIC_UNIT_PARITY_EN
    // Payload layout: {parity, result}
    localparam int PAYLOAD_W = WIDTH + 1;
`else
    localparam int PAYLOAD_W = WIDTH;
`endif

    logic [WIDTH-1:0]     opResult;
    logic [PAYLOAD_W-1:0] pushData;
    logic [PAYLOAD_W-1:0] headData;
    logic [WIDTH-1:0]     headResult;
    logic                 full;
    logic                 empty;
    logic                 doPush;
    logic                 doPop;
    logic [CNT_W-1:0]     txCount;

    // ------------------------------------------------------------------
    // Operation: zero-extend into the package word, keep the low WIDTH bits.
    // ------------------------------------------------------------------
    assign opResult = WIDTH'(f_logic_op(opcode_t'(iOp), LU_MAX_W'(iA), LU_MAX_W'(iB)));

`ifdef LOGIC_UNIT_PARITY_EN
    assign pushData = {^opResult, opResult};
`else
    assign pushData = opResult;
`endif

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign oReady = !full;
    assign oValid = !empty;
    assign doPush = iValid && !full;
    assign doPop  = iReady && !empty;

    logic_unit_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (PAYLOAD_W)
    ) uFifo (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .iPush  (doPush),
        .iData  (pushData),
        .iPop   (doPop),
        .oHead  (headData),
        .oFull  (full),
        .oEmpty (empty)
    );

    assign headResult = headData[WIDTH-1:0];

    // ------------------------------------------------------------------
    // Head outputs: masked to 0 while empty, so a reset (which empties the
    // queue asynchronously) clears them immediately without a clock.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before any branch; a path that
        // leaves a combinational output unassigned would infer a latch.
        oResult = '0;
        oZero   = 1'b0;
        oOnes   = 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
        oParity = 1'b0;
`endif
        if (!empty) begin
            oResult = headResult;
            oZero   = (headResult == '0);
            oOnes   = &headResult;
`ifdef LOGIC_UNIT_PARITY_EN
            oParity = headData[WIDTH];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Completed-transaction counter, wraps modulo 2^CNT_W.
    // ------------------------------------------------------------------
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            txCount <= '0;
        end else if (doPop) begin
            txCount <= txCount + 1'b1;
        end
    end

    assign oTxCount = txCount;

endmodule : logic_unit_pipe

// File: tb/tb_logic_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_pipe
//
// Self-checking bench for logic_unit_pipe (WIDTH=8, DEPTH=2, CNT_W=8).
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge. A scoreboard queue follows the expected queue contents and
// transaction count every cycle; a vector table and short hand-written
// sequences cover the opcode sweep, flags, backpressure, simultaneous
// push/pop, counter wrap and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;
    localparam int CNT_W = 8;

    logic             iClk   = 1'b0;
    logic             iRst_n = 1'b1;
    logic             iValid = 1'b0;
    logic             iReady = 1'b0;
    logic [2:0]       iOp    = '0;
    logic [WIDTH-1:0] iA     = '0;
    logic [WIDTH-1:0] iB     = '0;
    logic             oReady;
    logic             oValid;
    logic [WIDTH-1:0] oResult;
    logic             oZero;
    logic             oOnes;
    logic [CNT_W-1:0] oTxCount;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             oParity;
`endif

    logic_unit_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .iClk     (iClk),
        .iRst_n   (iRst_n),
        .iValid   (iValid),
        .oReady   (oReady),
        .iOp      (iOp),
        .iA       (iA),
        .iB       (iB),
        .oValid   (oValid),
        .iReady   (iReady),
        .oResult  (oResult),
        .oZero    (oZero),
        .oOnes    (oOnes),
        .oTxCount (oTxCount)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .oParity  (oParity)
`endif
    );

    always #5 iClk = ~iClk;

    int               nChecks = 0;
    int               nFails  = 0;
    logic [WIDTH-1:0] sb [$];
    logic [CNT_W-1:0] expTx = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~a;
            3'd3:    return a ^ b;
            3'd4:    return ~(a & b);
            3'd5:    return ~(a | b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    // Scoreboard: the queue model decides readiness, pops and pushes on its
    // own; the DUT outputs are only ever compared against it.
    always @(negedge iRst_n) begin
        sb.delete();
        expTx = '0;
    end

    always @(negedge iClk) begin
        if (iRst_n) begin
            logic             readyExp;
            logic [WIDTH-1:0] head;
            readyExp = (sb.size() < DEPTH);
            check("sb_txcount", 32'(oTxCount), 32'(expTx));
            check("sb_valid", 32'(oValid), 32'(sb.size() != 0));
            check("sb_ready", 32'(oReady), 32'(readyExp));
            if (sb.size() == 0) begin
                check("sb_empty_result", 32'(oResult), 32'(0));
                check("sb_empty_flags", 32'({oZero, oOnes}), 32'(0));
            end else begin
                head = sb[0];
                check("sb_result", 32'(oResult), 32'(head));
                check("sb_zero", 32'(oZero), 32'(head == '0));
                check("sb_ones", 32'(oOnes), 32'(head == '1));
`ifdef LOGIC_UNIT_PARITY_EN
                check("sb_parity", 32'(oParity), 32'(^head));
`endif
                if (iReady) begin
                    void'(sb.pop_front());
                    expTx = expTx + 1'b1;
                end
            end
            if (iValid && readyExp) begin
                sb.push_back(model(iOp, iA, iB));
            end
        end
    end

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ones;
    } vec_t;

    vec_t vecs [10];

    task automatic applyReset();
        iValid = 1'b0;
        iReady = 1'b0;
        iRst_n = 1'b0;
        @(posedge iClk);
        #2 iRst_n = 1'b1;
        @(posedge iClk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic accepted;

        vecs[0] = '{OP_AND,  8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0};
        vecs[1] = '{OP_OR,   8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0};
        vecs[2] = '{OP_NOT,  8'hC3, 8'h5A, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{OP_XOR,  8'hC3, 8'h5A, 8'h99, 1'b0, 1'b0};
        vecs[4] = '{OP_NAND, 8'hC3, 8'h5A, 8'hBD, 1'b0, 1'b0};
        vecs[5] = '{OP_NOR,  8'hC3, 8'h5A, 8'h24, 1'b0, 1'b0};
        vecs[6] = '{OP_XNOR, 8'hC3, 8'h5A, 8'h66, 1'b0, 1'b0};
        vecs[7] = '{OP_PASS, 8'hC3, 8'h5A, 8'hC3, 1'b0, 1'b0};
        vecs[8] = '{OP_XOR,  8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};
        vecs[9] = '{OP_OR,   8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b1};

        // ---------------- Reset state (inputs active, must be ignored) ----
        #2 iRst_n = 1'b0;
        iValid = 1'b1;
        iReady = 1'b1;
        iOp    = OP_PASS;
        iA     = 8'hA5;
        repeat (2) @(posedge iClk);
        #1;
        check("rst_valid", 32'(oValid), 32'(0));
        check("rst_ready", 32'(oReady), 32'(1));
        check("rst_result", 32'(oResult), 32'(0));
        check("rst_flags", 32'({oZero, oOnes}), 32'(0));
        check("rst_txcount", 32'(oTxCount), 32'(0));
`ifdef LOGIC_UNIT_PARITY_EN
        check("rst_parity", 32'(oParity), 32'(0));
`endif
        iValid = 1'b0;
        iReady = 1'b0;
        #1 iRst_n = 1'b1;
        @(posedge iClk);
        #1;

        // ---------------- Opcode sweep and flags, one-cycle latency -------
        for (int i = 0; i < 10; i++) begin
            iOp    = vecs[i].op;
            iA     = vecs[i].a;
            iB     = vecs[i].b;
            iValid = 1'b1;
            iReady = 1'b1;
            @(posedge iClk);
            #1;
            iValid = 1'b0;
            @(negedge iClk);
            check($sformatf("vec%0d_valid", i), 32'(oValid), 32'(1));
            check($sformatf("vec%0d_result", i), 32'(oResult), 32'(vecs[i].res));
            check($sformatf("vec%0d_zero", i), 32'(oZero), 32'(vecs[i].zero));
            check($sformatf("vec%0d_ones", i), 32'(oOnes), 32'(vecs[i].ones));
            @(posedge iClk);
            #1;
        end

        // ---------------- Backpressure -----------------------------------
        applyReset();
        iOp    = OP_AND;
        iA     = 8'hC3;
        iB     = 8'h5A;
        iValid = 1'b1;
        @(negedge iClk);
        check("bp_ready_empty", 32'(oReady), 32'(1));
        @(posedge iClk);
        #1;
        iOp = OP_OR;
        @(negedge iClk);
        check("bp_ready_one", 32'(oReady), 32'(1));
        @(posedge iClk);
        #1;
        iOp = OP_XOR;
        for (int k = 0; k < 3; k++) begin
            @(negedge iClk);
            check("bp_ready_full", 32'(oReady), 32'(0));
            check("bp_head_stable", 32'(oResult), 32'(8'h42));
            @(posedge iClk);
            #1;
        end
        iReady   = 1'b1;
        accepted = 1'b0;
        for (int k = 0; k < 8 && !accepted; k++) begin
            @(negedge iClk);
            if (oReady) accepted = 1'b1;
            @(posedge iClk);
            #1;
        end
        check("bp_third_accepted", 32'(accepted), 32'(1));
        iValid = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check("bp_txcount", 32'(oTxCount), 32'(3));
        check("bp_drained", 32'(oValid), 32'(0));
        @(posedge iClk);
        #1;

        // ---------------- Simultaneous push and pop at count 1 ------------
        iReady = 1'b0;
        iOp    = OP_PASS;
        iA     = 8'h11;
        iValid = 1'b1;
        @(posedge iClk);
        #1;
        iA     = 8'h22;
        iReady = 1'b1;
        @(negedge iClk);
        check("sim_head_first", 32'(oResult), 32'(8'h11));
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        @(negedge iClk);
        check("sim_head_second", 32'(oResult), 32'(8'h22));
        check("sim_valid_held", 32'(oValid), 32'(1));
        check("sim_count_one", 32'(oReady), 32'(1));
        @(posedge iClk);
        #1;
        @(negedge iClk);
        check("sim_empty", 32'(oValid), 32'(0));
        @(posedge iClk);
        #1;

        // ---------------- Transaction counter wrap ------------------------
        applyReset();
        iReady = 1'b1;
        iValid = 1'b1;
        for (int i = 0; i < 255; i++) begin
            iOp = 3'($urandom_range(0, 7));
            iA  = 8'($urandom);
            iB  = 8'($urandom);
            @(posedge iClk);
            #1;
        end
        iValid = 1'b0;
        repeat (3) @(posedge iClk);
        @(negedge iClk);
        check("wrap_255", 32'(oTxCount), 32'(255));
        @(posedge iClk);
        #1;
        iOp    = OP_PASS;
        iA     = 8'h3E;
        iValid = 1'b1;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        check("wrap_0", 32'(oTxCount), 32'(0));
        @(posedge iClk);
        #1;

        // ---------------- Reset mid-stream --------------------------------
        iOp    = OP_PASS;
        iA     = 8'h5A;
        iReady = 1'b1;
        iValid = 1'b1;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        @(posedge iClk);
        #1;
        iReady = 1'b0;
        iValid = 1'b1;
        iA     = 8'h81;
        repeat (2) @(posedge iClk);
        #1;
        @(negedge iClk);
        check("rm_pre_full", 32'(oReady), 32'(0));
        check("rm_pre_tx", 32'(oTxCount), 32'(1));
        #2 iRst_n = 1'b0;
        #1;
        check("rm_valid_now", 32'(oValid), 32'(0));
        check("rm_result_now", 32'(oResult), 32'(0));
        check("rm_tx_now", 32'(oTxCount), 32'(0));
        check("rm_ready_now", 32'(oReady), 32'(1));
        iReady = 1'b1;
        @(posedge iClk);
        #1;
        check("rm_held_valid", 32'(oValid), 32'(0));
        iRst_n = 1'b1;
        iOp    = OP_NOT;
        iA     = 8'hF8;
        iB     = 8'h00;
        @(posedge iClk);
        #1;
        iValid = 1'b0;
        @(negedge iClk);
        check("rm_fresh_valid", 32'(oValid), 32'(1));
        check("rm_fresh_result", 32'(oResult), 32'(8'h07));
`ifdef LOGIC_UNIT_PARITY_EN
        check("rm_fresh_parity", 32'(oParity), 32'(1));
`endif
        repeat (2) @(posedge iClk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_logic_unit_pipe

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the two-input AND/OR/NOT gate block.
- Applies one of eight bitwise operations to WIDTH-bit operands under a 3-bit opcode.
- Buffers results in a DEPTH-entry output queue with valid/ready handshakes on both sides, and reports per-result flags plus a completed-transaction count.
- Sits between operand sources (switch/register interfaces) and display or downstream logic in lab designs.

Parameters:
WIDTH, 8, operand/result width in bits (≥1)
DEPTH, 2, output queue entries (power of two, ≥2)
CNT_W, 8, width of transaction counter

Ports:
iClk  in  1  rising-edge clock
iRst_n  in  1  asynchronous, active-low reset
iValid  in  1  operand/opcode valid
oReady  out  1  unit can accept (queue not full)
iOp  in  3  opcode
iA  in  WIDTH  operand A
iB  in  WIDTH  operand B
oValid  out  1  queue head valid
iReady  in  1  downstream accepts head
oResult  out  WIDTH  head result
oZero  out  1  head result == 0
oOnes  out  1  head result all ones
oTxCount  out  CNT_W  results popped since reset, modulo 2^CNT_W

Behaviour:
- Reset: asynchronous on iRst_n low. Queue count, read pointer and write pointer go to 0. oValid=0, oResult=0, oZero=0, oOnes=0, oTxCount=0. Queue storage contents are don't-care.
- Opcodes:
  - 000 A&B
  - 001 A|B
  - 010 ~A (B ignored)
  - 011 A^B
  - 100 ~(A&B)
  - 101 ~(A|B)
  - 110 ~(A^B)
  - 111 A (pass)
- Push: when iValid && oReady at a clock edge, the result is computed combinationally and written to the queue. It appears at the head no earlier than the next cycle; latency is 1 cycle when the queue is empty.
- oReady: 1 when count < DEPTH, purely from registered count. It does not depend on iReady, so no pass-through when full. It reads 1 during reset since count=0; all inputs are ignored while iRst_n is low.
- Pop: when oValid && iReady at a clock edge, the head is removed and oTxCount increments.
- oValid: equals (count != 0).
- Head outputs: oResult, oZero and oOnes show the head entry. When the queue is empty they read 0.
- oZero/oOnes: computed from the stored result. For WIDTH=1 both are mutually exclusive by value.
- Simultaneous push and pop:
  - With 0<count<DEPTH: count unchanged, both pointers advance.
  - When full: only the pop occurs, because oReady=0.
  - When empty: only the push occurs; the new entry is visible next cycle.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. oTxCount wraps from 2^CNT_W−1 to 0.
- Stall behaviour: holding iReady=0 keeps the head and flags stable. Source data is not sampled while oReady=0.
- Reset mid-operation: all queued results are discarded immediately. A handshake in the same cycle as reset assertion has no effect.
- Queue control: no separate state machine. Queue control is the count (0..DEPTH) plus the two pointers.

Optional Feature:
- Macro: LOGIC_UNIT_PARITY_EN.
- Defined:
  - Adds output port oParity (1 bit) = XOR-reduction of the head result, stored per entry.
  - oParity is 0 when empty and 0 on reset.
- Undefined: the port and its storage are absent. All other behaviour is identical.

Decomposition:
- Package logic_unit_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_NOT, OP_XOR, OP_NAND, OP_NOR, OP_XNOR, OP_PASS
  - the 3-bit opcode typedef
  - function f_logic_op(op, a, b)
- One sub-module: logic_unit_fifo, the parametrised DEPTH×payload queue with count, pointers and full/empty. The top instantiates it with payload = result (plus parity when enabled).

Test Plan (WIDTH=8, DEPTH=2, CNT_W=8):
- Sweep all opcodes with A=8'hC3, B=8'h5A, iReady=1. Required results per opcode:
  - AND 8'h42
  - OR 8'hDB
  - NOT 8'h3C
  - XOR 8'h99
  - NAND 8'hBD
  - NOR 8'h24
  - XNOR 8'h66
  - PASS 8'hC3
  - Each appears one cycle after acceptance.
- Flags: XOR with A=B=8'hFF gives oResult=0, oZero=1. OR with A=8'hF0, B=8'h0F gives 8'hFF, oOnes=1.
- Backpressure:
  - Hold iReady=0 and push three ops. oReady drops to 0 after two accepts; the third is held at the source.
  - Release iReady: results pop in order and oTxCount reaches 3.
- Simultaneous: with count=1, push and pop together. Count stays 1, order is preserved, oValid stays 1.
- Counter wrap: perform 256 pops. oTxCount returns to 0.
- Reset mid-stream: assert iRst_n=0 asynchronously with 2 queued entries. oValid, oResult and oTxCount go to 0 immediately, before the next clock edge. After release, a fresh op produces the correct result. With LOGIC_UNIT_PARITY_EN defined, 8'h07 gives oParity=1.
